// File: rtl/serial_link_port.sv
// Game Boy serial link port: SB/SC registers, 8-bit MSB-first shifter with
// internal divided serial clock or synchronized external clock, one-cycle irq.
//
// state | meaning
// IDLE  | no transfer; serial edges ignored, divider held at 0
// XFER  | shifting; falling serial edge drives sout, rising edge samples sin
module serial_link_port #(
  parameter int HALF_PERIOD = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_sb,
  input  logic       wr_sc,
  input  logic [7:0] din,
  output logic [7:0] sb_out,
  output logic [7:0] sc_out,
  input  logic       sin,
  output logic       sout,
  input  logic       sck_in,
  output logic       sck_out,
  output logic       sck_oe,
  output logic       irq
);

  localparam int DW = $clog2(HALF_PERIOD);
  localparam logic [DW-1:0] DIV_TC = DW'(HALF_PERIOD - 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t      state, state_nx;
  logic [7:0]  sb, sb_nx;
  logic        start, start_nx;
  logic        clk_sel, clk_sel_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [DW-1:0] div, div_nx;
  logic        sck, sck_nx;
  logic        sout_r, sout_nx;
  logic        irq_r, irq_nx;
  logic        sync1, sync2, sync3;
  logic        ext_rise, ext_fall;
  logic        ser_rise, ser_fall;
  logic        div_tc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sb      <= 8'h00;
      start   <= 1'b0;
      clk_sel <= 1'b0;
      bit_cnt <= 3'd0;
      div     <= '0;
      sck     <= 1'b1;
      sout_r  <= 1'b1;
      irq_r   <= 1'b0;
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      sync3   <= 1'b1;
    end else begin
      state   <= state_nx;
      sb      <= sb_nx;
      start   <= start_nx;
      clk_sel <= clk_sel_nx;
      bit_cnt <= bit_cnt_nx;
      div     <= div_nx;
      sck     <= sck_nx;
      sout_r  <= sout_nx;
      irq_r   <= irq_nx;
      sync1   <= sck_in;
      sync2   <= sync1;
      sync3   <= sync2;
    end
  end

  // sync3 only exists to edge-detect sync2, giving the 3-clock action latency
  assign ext_rise = sync2 & ~sync3;
  assign ext_fall = ~sync2 & sync3;
  assign div_tc   = (div == DIV_TC);

  always_comb begin
    state_nx   = state;
    sb_nx      = sb;
    start_nx   = start;
    clk_sel_nx = clk_sel;
    bit_cnt_nx = bit_cnt;
    div_nx     = div;
    sck_nx     = sck;
    sout_nx    = sout_r;
    irq_nx     = 1'b0;
    ser_rise   = 1'b0;
    ser_fall   = 1'b0;

    if (state == XFER) begin
      if (clk_sel) begin
        ser_fall = div_tc & sck;
        ser_rise = div_tc & ~sck;
      end else begin
        ser_fall = ext_fall;
        ser_rise = ext_rise;
      end
    end

    if (wr_sc) begin
      // start, abort and restart all re-arm the counters and park sck high
      start_nx   = din[7];
      clk_sel_nx = din[0];
      bit_cnt_nx = 3'd0;
      div_nx     = '0;
      sck_nx     = 1'b1;
      state_nx   = din[7] ? XFER : IDLE;
    end else if (state == XFER) begin
      if (clk_sel) begin
        div_nx = div_tc ? '0 : div + DW'(1);
        if (div_tc) sck_nx = ~sck;
      end
      if (ser_fall) sout_nx = sb[7];
      if (ser_rise) begin
        sb_nx      = {sb[6:0], sin};
        bit_cnt_nx = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          state_nx = IDLE;
          start_nx = 1'b0;
          irq_nx   = 1'b1;
          div_nx   = '0;
        end
      end
    end

    if (wr_sb) sb_nx = din;
  end

  assign sb_out  = sb;
  assign sc_out  = {start, 6'b111111, clk_sel};
  assign sout    = sout_r;
  assign sck_out = sck;
  assign sck_oe  = clk_sel;
  assign irq     = irq_r;

endmodule

// File: tb/tb_serial_link_port.sv
// Directed-plus-random bench for serial_link_port with HALF_PERIOD=4; the
// expected bytes, bit order and edge times come from the transfer rules.
module tb_serial_link_port;

  localparam int HP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_sb = 1'b0;
  logic       wr_sc = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] sb_out;
  logic [7:0] sc_out;
  logic       sin = 1'b1;
  logic       sout;
  logic       sck_in = 1'b1;
  logic       sck_out;
  logic       sck_oe;
  logic       irq;

  int total = 0;
  int passed = 0;
  int irq_cnt = 0;

  serial_link_port #(.HALF_PERIOD(HP)) dut (
    .clk(clk), .reset(reset), .wr_sb(wr_sb), .wr_sc(wr_sc), .din(din),
    .sb_out(sb_out), .sc_out(sc_out), .sin(sin), .sout(sout),
    .sck_in(sck_in), .sck_out(sck_out), .sck_oe(sck_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (irq) irq_cnt <= irq_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sb(input logic [7:0] v);
    wr_sb = 1'b1; din = v;
    step();
    wr_sb = 1'b0;
  endtask

  task automatic write_sc(input logic [7:0] v);
    wr_sc = 1'b1; din = v;
    step();
    wr_sc = 1'b0;
  endtask

  // mode 0: random sin per bit, 1: loopback, 2: sin held 0
  task automatic run_int(input logic [7:0] sbv, input int mode);
    int n, falls, irqs, irq_n;
    logic prev;
    logic [7:0] exp;
    bit oe_ok;
    write_sb(sbv);
    write_sc(8'h81);
    n = 0; falls = 0; irqs = 0; irq_n = -1;
    prev = sck_out; exp = 8'h00; oe_ok = 1'b1;
    while (n < 16*HP + 8) begin
      step();
      n++;
      if (!sck_oe) oe_ok = 1'b0;
      if (irq) begin irqs++; irq_n = n; end
      if (prev && !sck_out) begin
        falls++;
        check("fall_time", n, HP + 2*HP*(falls-1));
        if (falls <= 8) check("sout_bit", sout, sbv[8-falls]);
        case (mode)
          1: sin = sout;
          2: sin = 1'b0;
          default: sin = 1'($urandom_range(0, 1));
        endcase
        exp = {exp[6:0], sin};
      end
      prev = sck_out;
    end
    check("int_falls", falls, 8);
    check("int_irq_count", irqs, 1);
    check("int_irq_time", irq_n, 16*HP);
    check("int_sb", sb_out, (mode == 1) ? sbv : exp);
    check("int_sc", sc_out, 8'h7F);
    check("int_sck_oe", oe_ok, 1);
  endtask

  task automatic run_ext(input logic [7:0] sbv, input logic [7:0] rx);
    int i0;
    bit sck_ok;
    write_sb(sbv);
    write_sc(8'h80);
    i0 = irq_cnt; sck_ok = 1'b1;
    check("ext_sck_oe", sck_oe, 0);
    for (int i = 0; i < 8; i++) begin
      sin = rx[7-i];
      sck_in = 1'b0;
      repeat (5) begin step(); if (!sck_out) sck_ok = 1'b0; end
      check("ext_sout_bit", sout, sbv[7-i]);
      sck_in = 1'b1;
      repeat (5) begin step(); if (!sck_out) sck_ok = 1'b0; end
    end
    repeat (3) step();
    check("ext_sb", sb_out, rx);
    check("ext_irq_count", irq_cnt - i0, 1);
    check("ext_sc", sc_out, 8'h7E);
    check("ext_sck_high", sck_ok, 1);
    for (int i = 0; i < 2; i++) begin
      sin = 1'($urandom_range(0, 1));
      sck_in = 1'b0; repeat (5) step();
      sck_in = 1'b1; repeat (5) step();
    end
    check("ext_idle_sb", sb_out, rx);
    check("ext_idle_irq", irq_cnt - i0, 1);
  endtask

  task automatic run_abort(input logic [7:0] sbv);
    int n, rises, i0;
    logic prev;
    logic [7:0] exp;
    i0 = irq_cnt;
    write_sb(sbv);
    write_sc(8'h81);
    n = 0; rises = 0; prev = sck_out; exp = sbv;
    while (rises < 3 && n < 200) begin
      step();
      n++;
      if (prev && !sck_out) sin = 1'($urandom_range(0, 1));
      if (!prev && sck_out) begin rises++; exp = {exp[6:0], sin}; end
      prev = sck_out;
    end
    check("abort_rises", rises, 3);
    write_sc(8'h01);
    repeat (80) step();
    check("abort_irq", irq_cnt - i0, 0);
    check("abort_sb", sb_out, exp);
    check("abort_sc", sc_out, 8'h7F);
    check("abort_sck", sck_out, 1);
  endtask

  initial begin
    int i0;
    repeat (2) step();
    check("rst_sb", sb_out, 8'h00);
    check("rst_sc", sc_out, 8'h7E);
    check("rst_sout", sout, 1);
    check("rst_sck", sck_out, 1);
    check("rst_oe", sck_oe, 0);
    check("rst_irq", irq, 0);
    reset = 1'b0;
    step();

    run_int(8'hA5, 1);
    run_int(8'hFF, 2);
    repeat (3) run_int(8'($urandom), 0);
    run_int(8'($urandom), 1);

    run_ext(8'h00, 8'h3C);
    repeat (2) run_ext(8'($urandom), 8'($urandom));

    run_abort(8'($urandom));
    run_int(8'($urandom), 0);

    // restart: a second start mid-byte re-times the whole transfer
    write_sc(8'h81);
    repeat (20) step();
    run_int(8'($urandom), 0);

    write_sb(8'($urandom));
    write_sc(8'h81);
    repeat (30) step();
    reset = 1'b1;
    step();
    check("mid_rst_sb", sb_out, 8'h00);
    check("mid_rst_sc", sc_out, 8'h7E);
    check("mid_rst_sout", sout, 1);
    check("mid_rst_sck", sck_out, 1);
    check("mid_rst_oe", sck_oe, 0);
    check("mid_rst_irq", irq, 0);
    reset = 1'b0;
    i0 = irq_cnt;
    repeat (80) step();
    check("mid_rst_no_irq", irq_cnt - i0, 0);
    check("mid_rst_sc_after", sc_out, 8'h7E);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_link_port.md
# serial_link_port

Game Boy serial link port: the 8-bit SB data register plus the SC control register, shifting one byte out on `sout` while shifting one byte in from `sin`, MSB first, using either an internally generated serial clock or an externally supplied one. The block sits on the CPU I/O bus at SB (0xFF01) and SC (0xFF02). It raises a one-cycle serial interrupt request to the interrupt controller when a transfer completes. It is the transmit/receive end that drives and samples the link cable.

## Interface
- `HALF_PERIOD`, 256: system clocks per half period of the internal serial clock (4.194304 MHz / 8192 Hz / 2); minimum 2.
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_sb`  in  1  CPU write strobe for SB, one cycle.
- `wr_sc`  in  1  CPU write strobe for SC, one cycle.
- `din`  in  8  CPU write data.
- `sb_out`  out  8  current SB contents.
- `sc_out`  out  8  SC readback, `{start, 6'b111111, clk_sel}`.
- `sin`  in  1  serial data in from the link.
- `sout`  out  1  serial data out to the link.
- `sck_in`  in  1  external serial clock, asynchronous to `clk`.
- `sck_out`  out  1  internal serial clock output.
- `sck_oe`  out  1  high when `sck_out` drives the link, i.e. while `clk_sel`=1.
- `irq`  out  1  serial interrupt request, one-cycle pulse.

## Operation
- Reset values:
  - `sb_out`=0x00
  - `sc_out`=0x7E
  - `sout`=1, `sck_out`=1, `sck_oe`=0, `irq`=0
  - state IDLE, bit count 0, divider 0
  - `sck_in` synchronizer flops = 1
- SC write latches `start`=`din[7]` and `clk_sel`=`din[0]`. Other `din` bits are ignored.
- States are IDLE and XFER. A 3-bit bit counter and a divider counter of width $clog2(HALF_PERIOD) run only in XFER.
- IDLE to XFER: an SC write with `din[7]`=1. The bit counter and divider clear, and `sck_out` stays 1.
- Falling serial edge: `sout` <= `sb[7]`.
- Rising serial edge: `sb` <= `{sb[6:0], sin_sampled}` and the bit counter increments.
- Internal clock (`clk_sel`=1):
  - The divider counts 0..HALF_PERIOD-1.
  - On terminal count, `sck_out` toggles and the divider wraps.
  - The `sck_out` transitions are the serial edges.
- External clock (`clk_sel`=0):
  - `sck_in` passes through a 2-flop synchronizer followed by an edge detector.
  - `sck_out` is held at 1.
  - The transfer waits indefinitely for edges.
  - External edges are ignored in IDLE.
- Completion: the rising edge that shifts the 8th bit also does all of the following in the same clock:
  - clears `start`
  - returns to IDLE
  - sets `irq` for the next cycle only
- Abort: an SC write with `din[7]`=0 during XFER goes to IDLE immediately. No `irq` is raised, `sck_out` is set to 1, and SB keeps its partially shifted value.
- Restart: an SC write with `din[7]`=1 during XFER clears the bit counter and divider, sets `sck_out`=1, and takes the new `clk_sel`.
- SB write during XFER overwrites SB and does not affect the bit count.
- SB write on the same cycle as a rising-edge shift: the CPU write wins and the shift is lost. Completion and `irq` still occur if that edge was the 8th.
- `sout` holds its value between falling edges and in IDLE.
- `reset` asserted mid-transfer returns every output to its reset value on the next edge; no `irq`.

## Timing
- Internal mode, SC write captured at edge E:
  - `sck_out` falls at edge E+HALF_PERIOD.
  - After that, `sck_out` toggles every HALF_PERIOD clocks.
  - The 8th rise is at E+16·HALF_PERIOD.
  - `irq`=1 during the cycle after that edge.
  - `sc_out[7]` reads 0 from that cycle onward.
- External mode:
  - A `sck_in` transition is acted on at the 3rd `clk` edge after it: 2 synchronizer stages plus 1 action.
  - `sck_in` high and low phases must each be at least 3 clocks.
- `sb_out` and `sc_out` are registered and reflect a CPU write on the cycle after the write strobe.
- `irq` is never wider than 1 cycle. Back-to-back transfers produce separate pulses.

## Test plan
- Internal loopback: HALF_PERIOD=4, `sin` tied to `sout`, SB=0xA5, SC write 0x81.
  - `sout` presents 1,0,1,0,0,1,0,1 on successive falls.
  - SB=0xA5 and `irq` pulses once, 64 clocks after the SC capture edge.
  - `sc_out`=0x7F afterwards.
- Internal receive: SB=0xFF, `sin`=0, SC=0x81 → SB=0x00, `sck_oe`=1 throughout, exactly 8 `sck_out` low pulses.
- External: SC=0x80, SB=0x00, drive 8 `sck_in` pulses of 5 clocks low / 5 high with `sin` presenting 0x3C MSB first → SB=0x3C, one `irq`, `sck_out` stays 1. Further pulses leave SB unchanged.
- Abort: start an internal transfer, then write SC=0x01 after 3 rising edges.
  - No `irq`; SB holds 3 shifted bits; `sc_out`=0x7F.
  - A new start completes a full 8 bits.
- Restart and reset: start an internal transfer and re-write SC=0x81 mid-byte → the full 16·HALF_PERIOD elapses from the re-write before `irq`. A separate run asserting `reset` mid-transfer → all outputs at reset values and no `irq`.
